fetch_ctrl: RTL and testbench
=============================

Name: fetch_ctrl

Overview:
- Fetch-stage controller that drives the PC register's next-value and enable inputs.
- Computes the next PC as sequential (PC+4) or branch target.
- Applies hazard stalls and issues IF/ID flush on taken branches.
- Runs a run/step/halt state machine under debug-unit control, drains the pipeline on a HALT instruction, and counts executed cycles for the debug unit.

Parameters:
- NB_PC, 32, width of program counter.
- NB_INSTR, 32, width of fetched instruction.
- NB_CNT, 32, width of cycle counter.
- HALT_INSTR, 32'hFFFF_FFFF, encoding that halts fetch.
- DRAIN_CYCLES, 4, cycles to let in-flight instructions retire after HALT.

Ports:
- clk, in, 1, clock.
- i_rst, in, 1, reset: synchronous and active-high.
- i_start, in, 1, debug pulse: continuous run.
- i_step, in, 1, debug pulse: advance one instruction.
- i_stall, in, 1, hazard unit stall request.
- i_branch_taken, in, 1, branch/jump resolved taken.
- i_branch_target, in, NB_PC, branch/jump target address.
- i_pc, in, NB_PC, current PC from PC register.
- i_instr, in, NB_INSTR, instruction fetched at i_pc.
- o_next_pc, out, NB_PC, value for PC register input.
- o_pc_en, out, 1, enable for PC register.
- o_flush, out, 1, flush IF/ID register.
- o_running, out, 1, state is RUN, STEP or DRAIN.
- o_halted, out, 1, state is HALTED.
- o_cycle_cnt, out, NB_CNT, cycles executed since reset.

Behaviour:
- States: IDLE, RUN, STEP, DRAIN, HALTED. State, drain counter and cycle counter are registered; all else combinational from state and inputs.
- Reset: state=IDLE, drain counter=0, o_cycle_cnt=0, o_running=0, o_halted=0. Since state is IDLE, o_pc_en=0 and o_flush=0. A reset at any time, including mid-RUN or DRAIN, returns to IDLE next edge.
- o_next_pc = i_branch_taken ? i_branch_target : i_pc + 4. The add is modulo 2^NB_PC, so 32'hFFFF_FFFC wraps to 0.
- halt_hit = (i_instr == HALT_INSTR) && !i_branch_taken. A HALT on the wrong path of a taken branch is ignored.
- active = state in {RUN, STEP}.
- o_pc_en = active && !halt_hit && (!i_stall || i_branch_taken). A taken branch overrides a simultaneous stall.
- o_flush = active && i_branch_taken.
- Transitions:
  - IDLE: i_start -> RUN; else i_step -> STEP; i_start and i_step together -> RUN.
  - RUN: halt_hit -> DRAIN (load drain counter = DRAIN_CYCLES-1); else stay. i_start/i_step ignored.
  - STEP: halt_hit -> DRAIN; else if o_pc_en -> IDLE; else (stalled) stay STEP until the advance happens. Exactly one PC update per step pulse.
  - DRAIN: o_pc_en=0. Counter decrements each cycle; at 0 -> HALTED. DRAIN lasts exactly DRAIN_CYCLES cycles.
  - HALTED: sticky; exits only via i_rst. All debug pulses ignored.
- o_cycle_cnt increments on every edge where state in {RUN, DRAIN}, or state==STEP with o_pc_en=1. Saturates at all-ones (no wrap).
- o_running/o_halted decode the current state, so they update one cycle after the transition condition.

Test Plan:
- Reset then i_start pulse, i_pc stepping 0,4,8, no stall/branch: o_pc_en=1 from the cycle after start, o_next_pc=i_pc+4, o_running=1, o_cycle_cnt counts 1,2,3.
- RUN with i_stall=1 for 2 cycles: o_pc_en=0 both cycles, o_next_pc still i_pc+4, counter keeps incrementing. Add i_branch_taken=1 with target 0x40 during stall: o_pc_en=1, o_next_pc=0x40, o_flush=1.
- IDLE, i_step pulse with i_stall=1 for 3 cycles: stays STEP, o_pc_en=0, counter unchanged. Stall drops: single o_pc_en=1 cycle, back to IDLE, o_cycle_cnt=1.
- RUN, i_instr=32'hFFFF_FFFF: o_pc_en=0 that cycle, DRAIN for exactly 4 cycles, then o_halted=1, o_running=0. i_start/i_step afterwards have no effect, count frozen.
- RUN, i_instr=HALT with i_branch_taken=1 to 0x100: no halt, o_next_pc=0x100, o_flush=1, remains RUN.
- i_pc=32'hFFFF_FFFC gives o_next_pc=0. Assert i_rst mid-DRAIN: next cycle IDLE, o_cycle_cnt=0, o_halted=0.

Source files
------------

// File: rtl/fetch_ctrl.sv
// Fetch-stage controller: selects the next PC, gates the PC register on stalls,
// flushes IF/ID on taken branches and runs the debug run/step/halt state machine.
module fetch_ctrl #(
  parameter int unsigned          NB_PC        = 32,
  parameter int unsigned          NB_INSTR     = 32,
  parameter int unsigned          NB_CNT       = 32,
  parameter logic [NB_INSTR-1:0]  HALT_INSTR   = 32'hFFFF_FFFF,
  parameter int unsigned          DRAIN_CYCLES = 4
) (
  input  logic                clk,
  input  logic                i_rst,
  input  logic                i_start,
  input  logic                i_step,
  input  logic                i_stall,
  input  logic                i_branch_taken,
  input  logic [NB_PC-1:0]    i_branch_target,
  input  logic [NB_PC-1:0]    i_pc,
  input  logic [NB_INSTR-1:0] i_instr,
  output logic [NB_PC-1:0]    o_next_pc,
  output logic                o_pc_en,
  output logic                o_flush,
  output logic                o_running,
  output logic                o_halted,
  output logic [NB_CNT-1:0]   o_cycle_cnt
);

  localparam int unsigned NB_DRAIN = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RUN,
    ST_STEP,
    ST_DRAIN,
    ST_HALTED
  } state_t;

  state_t              state_q, state_d;
  logic [NB_DRAIN-1:0] drain_q, drain_d;
  logic [NB_CNT-1:0]   cycle_cnt_q, cycle_cnt_d;
  logic                running_q, running_d;
  logic                halted_q, halted_d;

  logic halt_hit;
  logic active;
  logic pc_en;
  logic count_en;

  // A HALT fetched on the wrong path of a taken branch must not stop the core.
  assign halt_hit = (i_instr == HALT_INSTR) && !i_branch_taken;
  assign active   = (state_q == ST_RUN) || (state_q == ST_STEP);
  assign pc_en    = active && !halt_hit && (!i_stall || i_branch_taken);
  assign count_en = (state_q == ST_RUN) || (state_q == ST_DRAIN) ||
                    ((state_q == ST_STEP) && pc_en);

  assign o_next_pc   = i_branch_taken ? i_branch_target : (i_pc + NB_PC'(4));
  assign o_pc_en     = pc_en;
  assign o_flush     = active && i_branch_taken;
  assign o_running   = running_q;
  assign o_halted    = halted_q;
  assign o_cycle_cnt = cycle_cnt_q;

  always_comb begin
    state_d     = state_q;
    drain_d     = drain_q;
    cycle_cnt_d = cycle_cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (i_start)     state_d = ST_RUN;
        else if (i_step) state_d = ST_STEP;
      end
      ST_RUN: begin
        if (halt_hit) begin
          state_d = ST_DRAIN;
          drain_d = NB_DRAIN'(DRAIN_CYCLES - 1);
        end
      end
      ST_STEP: begin
        if (halt_hit) begin
          state_d = ST_DRAIN;
          drain_d = NB_DRAIN'(DRAIN_CYCLES - 1);
        end else if (pc_en) begin
          state_d = ST_IDLE;
        end
      end
      ST_DRAIN: begin
        if (drain_q == '0) state_d = ST_HALTED;
        else               drain_d = drain_q - NB_DRAIN'(1);
      end
      ST_HALTED: state_d = ST_HALTED;
      default:   state_d = ST_IDLE;
    endcase

    // Saturate rather than wrap so the debug unit never sees a small count after overflow.
    if (count_en && (cycle_cnt_q != {NB_CNT{1'b1}}))
      cycle_cnt_d = cycle_cnt_q + NB_CNT'(1);

    running_d = (state_d == ST_RUN) || (state_d == ST_STEP) || (state_d == ST_DRAIN);
    halted_d  = (state_d == ST_HALTED);
  end

  always_ff @(posedge clk) begin
    if (i_rst) begin
      state_q     <= ST_IDLE;
      drain_q     <= '0;
      cycle_cnt_q <= '0;
      running_q   <= 1'b0;
      halted_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      drain_q     <= drain_d;
      cycle_cnt_q <= cycle_cnt_d;
      running_q   <= running_d;
      halted_q    <= halted_d;
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: per-scenario stimulus tables, expected outputs queued
// as each cycle is driven and compared at the following falling edge.
module tb_fetch_ctrl;

  localparam int W = 68;
  localparam logic [31:0] HALT = 32'hFFFF_FFFF;

  typedef struct packed {
    logic        rst, start, step, stall, br;
    logic [31:0] tgt, pc, instr;
  } stim_t;

  typedef struct packed {
    logic [31:0] next_pc;
    logic        en, flush, run, halt;
    logic [31:0] cnt;
  } exp_t;

  logic        clk = 1'b0;
  logic        i_rst = 1'b0, i_start = 1'b0, i_step = 1'b0, i_stall = 1'b0, i_branch_taken = 1'b0;
  logic [31:0] i_branch_target = '0, i_pc = '0, i_instr = '0;
  logic [31:0] o_next_pc, o_cycle_cnt;
  logic        o_pc_en, o_flush, o_running, o_halted;

  logic [W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  // clock / reset
  always #5 clk = ~clk;

  fetch_ctrl dut (
    .clk(clk), .i_rst(i_rst), .i_start(i_start), .i_step(i_step), .i_stall(i_stall),
    .i_branch_taken(i_branch_taken), .i_branch_target(i_branch_target), .i_pc(i_pc),
    .i_instr(i_instr), .o_next_pc(o_next_pc), .o_pc_en(o_pc_en), .o_flush(o_flush),
    .o_running(o_running), .o_halted(o_halted), .o_cycle_cnt(o_cycle_cnt)
  );

  function automatic stim_t s(input logic rst, start, step, stall, br,
                              input logic [31:0] tgt, pc, instr);
    s = '{rst, start, step, stall, br, tgt, pc, instr};
  endfunction

  function automatic exp_t e(input logic [31:0] next_pc, input logic en, flush, run, halt,
                             input logic [31:0] cnt);
    e = '{next_pc, en, flush, run, halt, cnt};
  endfunction

  // driver tasks
  task automatic drive(input stim_t st);
    @(posedge clk); #1;
    i_rst = st.rst; i_start = st.start; i_step = st.step; i_stall = st.stall;
    i_branch_taken = st.br; i_branch_target = st.tgt; i_pc = st.pc; i_instr = st.instr;
  endtask

  task automatic do_reset();
    drive(s(1, 0, 0, 0, 0, 0, 0, 0));
    drive(s(0, 0, 0, 0, 0, 0, 0, 0));
  endtask

  task automatic test_reset();
    stim_t st[$]; exp_t ex[$]; exp_t got, want;
    do_reset();
    st.push_back(s(1, 0, 0, 0, 0, 0, 32'h0, 0));  ex.push_back(e(32'h4,  0, 0, 0, 0, 0));
    st.push_back(s(1, 1, 1, 0, 0, 0, 32'h8, 0));  ex.push_back(e(32'hC,  0, 0, 0, 0, 0));
    st.push_back(s(0, 0, 0, 0, 0, 0, 32'h8, 0));  ex.push_back(e(32'hC,  0, 0, 0, 0, 0));
    for (int i = 0; i < st.size(); i++) begin
      drive(st[i]);
      exp_q.push_back(ex[i]);
      @(negedge clk);
      got  = {o_next_pc, o_pc_en, o_flush, o_running, o_halted, o_cycle_cnt};
      want = exp_q.pop_front();
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL reset[%0d]: got pc=%h en=%b fl=%b run=%b hlt=%b cnt=%0d, expected pc=%h en=%b fl=%b run=%b hlt=%b cnt=%0d",
                 i, got.next_pc, got.en, got.flush, got.run, got.halt, got.cnt,
                 want.next_pc, want.en, want.flush, want.run, want.halt, want.cnt);
      end
    end
  endtask

  // Run, stall, branch-over-stall, branch past a HALT, real HALT, drain, sticky halt.
  task automatic test_run_halt();
    stim_t st[$]; exp_t ex[$]; exp_t got, want;
    do_reset();
    st.push_back(s(0, 1, 0, 0, 0, 0,      32'h0,   0));    ex.push_back(e(32'h4,   0, 0, 0, 0, 0));
    st.push_back(s(0, 0, 0, 0, 0, 0,      32'h0,   0));    ex.push_back(e(32'h4,   1, 0, 1, 0, 0));
    st.push_back(s(0, 0, 0, 0, 0, 0,      32'h4,   0));    ex.push_back(e(32'h8,   1, 0, 1, 0, 1));
    st.push_back(s(0, 0, 0, 0, 0, 0,      32'h8,   0));    ex.push_back(e(32'hC,   1, 0, 1, 0, 2));
    st.push_back(s(0, 0, 0, 0, 0, 0,      32'hC,   0));    ex.push_back(e(32'h10,  1, 0, 1, 0, 3));
    st.push_back(s(0, 0, 0, 1, 0, 0,      32'h10,  0));    ex.push_back(e(32'h14,  0, 0, 1, 0, 4));
    st.push_back(s(0, 0, 0, 1, 0, 0,      32'h10,  0));    ex.push_back(e(32'h14,  0, 0, 1, 0, 5));
    st.push_back(s(0, 0, 0, 1, 1, 32'h40, 32'h10,  0));    ex.push_back(e(32'h40,  1, 1, 1, 0, 6));
    st.push_back(s(0, 0, 0, 0, 0, 0,      32'h40,  0));    ex.push_back(e(32'h44,  1, 0, 1, 0, 7));
    st.push_back(s(0, 0, 0, 0, 1, 32'h100, 32'h44, HALT)); ex.push_back(e(32'h100, 1, 1, 1, 0, 8));
    st.push_back(s(0, 0, 0, 0, 0, 0,      32'h100, 0));    ex.push_back(e(32'h104, 1, 0, 1, 0, 9));
    st.push_back(s(0, 0, 0, 0, 0, 0,      32'h104, HALT)); ex.push_back(e(32'h108, 0, 0, 1, 0, 10));
    for (int k = 0; k < 4; k++) begin
      st.push_back(s(0, 0, 0, 0, 0, 0,    32'h104, 0));    ex.push_back(e(32'h108, 0, 0, 1, 0, 11 + k));
    end
    st.push_back(s(0, 1, 1, 0, 0, 0,      32'h104, 0));    ex.push_back(e(32'h108, 0, 0, 0, 1, 15));
    st.push_back(s(0, 0, 0, 0, 1, 32'h80, 32'h104, 0));    ex.push_back(e(32'h80,  0, 0, 0, 1, 15));
    st.push_back(s(0, 0, 1, 0, 0, 0,      32'h104, 0));    ex.push_back(e(32'h108, 0, 0, 0, 1, 15));
    for (int i = 0; i < st.size(); i++) begin
      drive(st[i]);
      exp_q.push_back(ex[i]);
      @(negedge clk);
      got  = {o_next_pc, o_pc_en, o_flush, o_running, o_halted, o_cycle_cnt};
      want = exp_q.pop_front();
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL run_halt[%0d]: got pc=%h en=%b fl=%b run=%b hlt=%b cnt=%0d, expected pc=%h en=%b fl=%b run=%b hlt=%b cnt=%0d",
                 i, got.next_pc, got.en, got.flush, got.run, got.halt, got.cnt,
                 want.next_pc, want.en, want.flush, want.run, want.halt, want.cnt);
      end
    end
  endtask

  // Single step held off by a stall, then an unstalled step.
  task automatic test_step();
    stim_t st[$]; exp_t ex[$]; exp_t got, want;
    do_reset();
    st.push_back(s(0, 0, 1, 1, 0, 0, 32'h200, 0)); ex.push_back(e(32'h204, 0, 0, 0, 0, 0));
    for (int k = 0; k < 3; k++) begin
      st.push_back(s(0, 0, 0, 1, 0, 0, 32'h200, 0)); ex.push_back(e(32'h204, 0, 0, 1, 0, 0));
    end
    st.push_back(s(0, 0, 0, 0, 0, 0, 32'h200, 0)); ex.push_back(e(32'h204, 1, 0, 1, 0, 0));
    st.push_back(s(0, 0, 0, 0, 0, 0, 32'h204, 0)); ex.push_back(e(32'h208, 0, 0, 0, 0, 1));
    st.push_back(s(0, 0, 0, 0, 0, 0, 32'h204, 0)); ex.push_back(e(32'h208, 0, 0, 0, 0, 1));
    st.push_back(s(0, 0, 1, 0, 0, 0, 32'h300, 0)); ex.push_back(e(32'h304, 0, 0, 0, 0, 1));
    st.push_back(s(0, 0, 0, 0, 0, 0, 32'h300, 0)); ex.push_back(e(32'h304, 1, 0, 1, 0, 1));
    st.push_back(s(0, 0, 0, 0, 0, 0, 32'h304, 0)); ex.push_back(e(32'h308, 0, 0, 0, 0, 2));
    for (int i = 0; i < st.size(); i++) begin
      drive(st[i]);
      exp_q.push_back(ex[i]);
      @(negedge clk);
      got  = {o_next_pc, o_pc_en, o_flush, o_running, o_halted, o_cycle_cnt};
      want = exp_q.pop_front();
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL step[%0d]: got pc=%h en=%b fl=%b run=%b hlt=%b cnt=%0d, expected pc=%h en=%b fl=%b run=%b hlt=%b cnt=%0d",
                 i, got.next_pc, got.en, got.flush, got.run, got.halt, got.cnt,
                 want.next_pc, want.en, want.flush, want.run, want.halt, want.cnt);
      end
    end
  endtask

  // PC wrap, start+step together, and reset arriving mid-drain.
  task automatic test_wrap_reset_drain();
    stim_t st[$]; exp_t ex[$]; exp_t got, want;
    do_reset();
    st.push_back(s(0, 1, 1, 0, 0, 0, 32'hFFFF_FFFC, 0));    ex.push_back(e(32'h0, 0, 0, 0, 0, 0));
    st.push_back(s(0, 0, 0, 0, 0, 0, 32'hFFFF_FFFC, 0));    ex.push_back(e(32'h0, 1, 0, 1, 0, 0));
    st.push_back(s(0, 0, 0, 0, 0, 0, 32'h0,         HALT)); ex.push_back(e(32'h4, 0, 0, 1, 0, 1));
    st.push_back(s(0, 0, 0, 0, 0, 0, 32'h0,         0));    ex.push_back(e(32'h4, 0, 0, 1, 0, 2));
    st.push_back(s(1, 0, 0, 0, 0, 0, 32'h0,         0));    ex.push_back(e(32'h4, 0, 0, 1, 0, 3));
    st.push_back(s(0, 0, 0, 0, 0, 0, 32'h0,         0));    ex.push_back(e(32'h4, 0, 0, 0, 0, 0));
    st.push_back(s(0, 0, 0, 0, 0, 0, 32'h0,         0));    ex.push_back(e(32'h4, 0, 0, 0, 0, 0));
    for (int i = 0; i < st.size(); i++) begin
      drive(st[i]);
      exp_q.push_back(ex[i]);
      @(negedge clk);
      got  = {o_next_pc, o_pc_en, o_flush, o_running, o_halted, o_cycle_cnt};
      want = exp_q.pop_front();
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL wrap_rst[%0d]: got pc=%h en=%b fl=%b run=%b hlt=%b cnt=%0d, expected pc=%h en=%b fl=%b run=%b hlt=%b cnt=%0d",
                 i, got.next_pc, got.en, got.flush, got.run, got.halt, got.cnt,
                 want.next_pc, want.en, want.flush, want.run, want.halt, want.cnt);
      end
    end
  endtask

  initial begin
    test_reset();
    test_run_halt();
    test_step();
    test_wrap_reset_drain();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
